// File: rtl/hp_bar_animator_if.sv
// Control bus between battle logic and the HP bar animator.
interface hp_bar_animator_if;
  logic       load;
  logic       snap;
  logic [7:0] target_hp;
  logic [7:0] max_hp;
  logic       busy;
  logic       done;
  logic [7:0] disp_hp;

  modport master (
    output load, snap, target_hp, max_hp,
    input  busy, done, disp_hp
  );

  modport slave (
    input  load, snap, target_hp, max_hp,
    output busy, done, disp_hp
  );
endinterface

// File: rtl/hp_bar_animator.sv
// HP bar overlay: animates displayed HP toward a target once per frame,
// recomputes the fill width with an 8-cycle restoring divider, and draws
// the bar combinationally from DrawX/DrawY against registered state.
module hp_bar_animator #(
  parameter logic [9:0] BAR_X = 10'd400,
  parameter logic [9:0] BAR_Y = 10'd300,
  parameter logic [7:0] BAR_W = 8'd100,
  parameter logic [9:0] BAR_H = 10'd6,
  parameter logic [7:0] STEP  = 8'd1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     frame_clk,
  input  logic [9:0]               DrawX,
  input  logic [9:0]               DrawY,
  hp_bar_animator_if.slave         bus,
  output logic                     is_battleinfo_bar,
  output logic [7:0]               hp_r,
  output logic [7:0]               hp_g,
  output logic [7:0]               hp_b
);

  localparam int unsigned HP_W   = 8;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned PIX_W  = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_STEP,
    S_DIV,
    S_FINISH
  } state_e;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [HP_W-1:0]   disp_q, disp_d;
  logic [HP_W-1:0]   tgt_q, tgt_d;
  logic [HP_W-1:0]   max_q, max_d;
  logic [HP_W-1:0]   fill_q, fill_d;
  logic [HP_W-1:0]   rem_q, rem_d;
  logic [HP_W-1:0]   nlo_q, nlo_d;
  logic [HP_W-1:0]   quo_q, quo_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              frame_clk_q;

  logic              rise;
  logic              div_start;
  logic [HP_W-1:0]   tgt_clamp;
  logic [HP_W:0]     down9, up9, trial;
  logic              ge;
  logic [PROD_W-1:0] prod;

  assign rise = frame_clk & ~frame_clk_q;

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.disp_hp = disp_q;

  // Frame edge detector register.
  always_ff @(posedge Clk) begin
    if (Reset) frame_clk_q <= 1'b0;
    else       frame_clk_q <= frame_clk;
  end

  // State and datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      disp_q  <= '0;
      tgt_q   <= '0;
      max_q   <= '0;
      fill_q  <= '0;
      rem_q   <= '0;
      nlo_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      disp_q  <= disp_d;
      tgt_q   <= tgt_d;
      max_q   <= max_d;
      fill_q  <= fill_d;
      rem_q   <= rem_d;
      nlo_q   <= nlo_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, HP stepping and divider iteration.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    disp_d    = disp_q;
    tgt_d     = tgt_q;
    max_d     = max_q;
    fill_d    = fill_q;
    rem_d     = rem_q;
    nlo_d     = nlo_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    div_start = 1'b0;
    tgt_clamp = (bus.target_hp > bus.max_hp) ? bus.max_hp : bus.target_hp;
    down9     = {1'b0, disp_q} - {1'b0, STEP};
    up9       = {1'b0, disp_q} + {1'b0, STEP};
    trial     = {rem_q, nlo_q[HP_W-1]};
    ge        = (trial >= {1'b0, max_q});
    prod      = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          tgt_d  = tgt_clamp;
          max_d  = bus.max_hp;
          busy_d = 1'b1;
          if (bus.snap) begin
            disp_d    = tgt_clamp;
            div_start = 1'b1;
            state_d   = S_DIV;
          end else begin
            state_d = S_WAIT_FRAME;
          end
        end
      end
      S_WAIT_FRAME: begin
        if (rise) state_d = S_STEP;
      end
      S_STEP: begin
        // 9-bit arithmetic: a borrow or carry clamps to the target.
        if (disp_q > tgt_q) begin
          if (down9[HP_W] || (down9[HP_W-1:0] < tgt_q)) disp_d = tgt_q;
          else                                           disp_d = down9[HP_W-1:0];
        end else if (disp_q < tgt_q) begin
          if (up9 > {1'b0, tgt_q}) disp_d = tgt_q;
          else                     disp_d = up9[HP_W-1:0];
        end
        div_start = 1'b1;
        state_d   = S_DIV;
      end
      S_DIV: begin
        rem_d = ge ? HP_W'(trial - {1'b0, max_q}) : trial[HP_W-1:0];
        nlo_d = {nlo_q[HP_W-2:0], 1'b0};
        quo_d = {quo_q[HP_W-2:0], ge};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = S_FINISH;
      end
      S_FINISH: begin
        // Displayed HP above the latched max (max lowered mid-animation)
        // would overflow the 8-bit quotient; pin the bar full instead.
        if (max_q == '0)         fill_d = '0;
        else if (disp_q > max_q) fill_d = BAR_W;
        else                     fill_d = quo_q;
        if (disp_q == tgt_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_FRAME;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Seed the divider from the HP value being written this cycle; the
    // high numerator byte is already below the divisor when disp <= max,
    // so eight iterations yield the full quotient.
    if (div_start) begin
      prod  = PROD_W'(disp_d) * PROD_W'(BAR_W);
      rem_d = prod[PROD_W-1:HP_W];
      nlo_d = prod[HP_W-1:0];
      quo_d = '0;
      cnt_d = '0;
    end
  end

  logic [PIX_W-1:0] px_x, px_y, bx, by, bx_end, by_end, five_fill, two_fill;
  logic             in_outer, in_inner;

  // Bar geometry and colour selection.
  always_comb begin
    px_x      = {1'b0, DrawX};
    px_y      = {1'b0, DrawY};
    bx        = {1'b0, BAR_X};
    by        = {1'b0, BAR_Y};
    bx_end    = bx + PIX_W'(BAR_W);
    by_end    = by + PIX_W'(BAR_H);
    five_fill = PIX_W'(fill_q) * PIX_W'(5);
    two_fill  = PIX_W'(fill_q) * PIX_W'(2);
    in_outer  = (px_x + PIX_W'(1) >= bx) && (px_x <= bx_end) &&
                (px_y + PIX_W'(1) >= by) && (px_y <= by_end);
    in_inner  = (px_x >= bx) && (px_x < bx_end) &&
                (px_y >= by) && (px_y < by_end);

    is_battleinfo_bar = in_outer;
    hp_r = 8'h00;
    hp_g = 8'h00;
    hp_b = 8'h00;
    if (in_inner) begin
      if ((px_x - bx) < PIX_W'(fill_q)) begin
        if (five_fill <= PIX_W'(BAR_W)) begin
          hp_r = 8'hf8; hp_g = 8'h38; hp_b = 8'h08;
        end else if (two_fill <= PIX_W'(BAR_W)) begin
          hp_r = 8'hf8; hp_g = 8'hd0; hp_b = 8'h08;
        end else begin
          hp_r = 8'h38; hp_g = 8'hb8; hp_b = 8'h18;
        end
      end else begin
        hp_r = 8'h50; hp_g = 8'h50; hp_b = 8'h50;
      end
    end
  end

endmodule

// File: tb/tb_hp_bar_animator.sv
// Scoreboard bench for hp_bar_animator: each accepted load that should
// complete pushes its expected completion; a monitor checks every done.
module tb_hp_bar_animator;

  localparam int BX   = 400;
  localparam int BY   = 300;
  localparam int RED  = 24'hf83808;
  localparam int YEL  = 24'hf8d008;
  localparam int GRN  = 24'h38b818;
  localparam int GREY = 24'h505050;
  localparam int BLK  = 24'h000000;

  typedef struct {
    int disp;
    int cyc;
    int frames;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_clk;
  logic [9:0] draw_x, draw_y;
  logic       is_bar;
  logic [7:0] r, g, b;

  hp_bar_animator_if bus ();

  hp_bar_animator dut (
    .Clk               (clk),
    .Reset             (rst),
    .frame_clk         (frame_clk),
    .DrawX             (draw_x),
    .DrawY             (draw_y),
    .bus               (bus),
    .is_battleinfo_bar (is_bar),
    .hp_r              (r),
    .hp_g              (g),
    .hp_b              (b)
  );

  always #5 clk = ~clk;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   frames = 0;
  exp_t sb_q[$];
  exp_t e_mon;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic px(input string name, input int dx, input int dy,
                    input int exp_in, input int exp_rgb);
    draw_x = 10'(dx);
    draw_y = 10'(dy);
    #1;
    chk({name, "_in"}, int'(is_bar), exp_in);
    chk({name, "_rgb"}, int'({r, g, b}), exp_rgb);
  endtask

  task automatic do_load(input int tgt, input int mx, input bit snap,
                         input bit push, input int exp_disp,
                         input int cyc_rel, input int exp_frames,
                         input bit with_rise);
    @(posedge clk); #1;
    bus.load      = 1'b1;
    bus.snap      = snap;
    bus.target_hp = 8'(tgt);
    bus.max_hp    = 8'(mx);
    if (with_rise) frame_clk = 1'b1;
    frames = 0;
    if (push) sb_q.push_back('{exp_disp, (cyc_rel < 0) ? -1 : cyc + cyc_rel, exp_frames});
    @(posedge clk); #1;
    bus.load = 1'b0;
    bus.snap = 1'b0;
  endtask

  task automatic frame();
    frame_clk = 1'b1;
    frames++;
    repeat (4) @(posedge clk);
    #1 frame_clk = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic run_frames(input string name, input int maxf);
    int n;
    n = 0;
    while (bus.busy && n < maxf) begin
      frame();
      n++;
    end
    chk({name, "_busy_clear"}, int'(bus.busy), 0);
  endtask

  task automatic wait_snap(input string name);
    repeat (12) @(posedge clk);
    #1;
    chk({name, "_busy_clear"}, int'(bus.busy), 0);
  endtask

  // Completion monitor: every done must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 disp=%0d expected no done (cycle %0d)",
                 bus.disp_hp, cyc);
      end else begin
        e_mon = sb_q.pop_front();
        chk("done_disp", int'(bus.disp_hp), e_mon.disp);
        chk("done_busy", int'(bus.busy), 0);
        if (e_mon.cyc >= 0)    chk("done_latency", cyc, e_mon.cyc);
        if (e_mon.frames >= 0) chk("done_frames", frames, e_mon.frames);
      end
    end
  end

  initial begin
    rst           = 1'b1;
    frame_clk     = 1'b0;
    draw_x        = '0;
    draw_y        = '0;
    bus.load      = 1'b0;
    bus.snap      = 1'b0;
    bus.target_hp = '0;
    bus.max_hp    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_disp", int'(bus.disp_hp), 0);
    px("rst_interior", BX + 5, BY + 2, 1, GREY);
    px("rst_border",   BX - 1, BY + 2, 1, BLK);
    px("rst_outside",  BX - 2, BY + 2, 0, BLK);

    // Snap load 50/100: fill 50, yellow up to x+49
    do_load(50, 100, 1'b1, 1'b1, 50, 10, -1, 1'b0);
    wait_snap("snap50");
    px("snap50_last_fill", BX + 49, BY + 2, 1, YEL);
    px("snap50_first_empty", BX + 50, BY + 2, 1, GREY);

    // Animated drain 50 -> 20, one HP per frame
    do_load(20, 100, 1'b0, 1'b1, 20, -1, 30, 1'b0);
    for (int f = 1; f <= 30; f++) begin
      frame();
      chk("drain_disp", int'(bus.disp_hp), 50 - f);
      if (f == 29) px("drain_fill21", BX, BY + 2, 1, YEL);
    end
    chk("drain_busy_clear", int'(bus.busy), 0);
    px("drain_last_fill", BX + 19, BY + 2, 1, RED);
    px("drain_first_empty", BX + 20, BY + 2, 1, GREY);

    // Non-round divisor 45
    do_load(45, 45, 1'b1, 1'b1, 45, 10, -1, 1'b0);
    wait_snap("max45");
    px("max45_full", BX + 99, BY + 5, 1, GRN);
    px("max45_right_border", BX + 100, BY + 5, 1, BLK);
    do_load(44, 45, 1'b0, 1'b1, 44, -1, 1, 1'b0);
    run_frames("max45_step", 5);
    px("max45_fill97_last", BX + 96, BY, 1, GRN);
    px("max45_fill97_empty", BX + 97, BY, 1, GREY);

    // Clamp 200 -> 100, with an ignored load mid-animation
    do_load(200, 100, 1'b0, 1'b1, 100, -1, 56, 1'b0);
    for (int f = 0; f < 3; f++) frame();
    bus.load      = 1'b1;
    bus.snap      = 1'b1;
    bus.target_hp = 8'd0;
    @(posedge clk); #1;
    bus.load = 1'b0;
    bus.snap = 1'b0;
    @(posedge clk); #1;
    chk("ignored_load_disp", int'(bus.disp_hp), 47);
    run_frames("clamp", 80);
    px("clamp_full", BX + 99, BY + 1, 1, GRN);

    // Reset mid-animation: no done expected
    do_load(0, 100, 1'b0, 1'b0, 0, -1, -1, 1'b0);
    for (int f = 0; f < 5; f++) frame();
    frame_clk = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    frame_clk = 1'b0;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_disp", int'(bus.disp_hp), 0);
    px("midrst_grey", BX, BY + 2, 1, GREY);
    repeat (20) @(posedge clk);
    #1;

    // max_hp = 0 forces an empty bar
    do_load(30, 100, 1'b1, 1'b1, 30, 10, -1, 1'b0);
    wait_snap("snap30");
    px("snap30_fill", BX + 29, BY + 2, 1, YEL);
    do_load(50, 0, 1'b1, 1'b1, 0, 10, -1, 1'b0);
    wait_snap("max0");
    px("max0_first", BX, BY + 2, 1, GREY);
    px("max0_prev_fill", BX + 29, BY + 2, 1, GREY);

    // Load and frame edge together: the edge is dropped
    do_load(10, 100, 1'b0, 1'b1, 10, -1, 10, 1'b1);
    repeat (2) @(posedge clk);
    #1 frame_clk = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("lr_disp_held", int'(bus.disp_hp), 0);
    chk("lr_busy", int'(bus.busy), 1);
    run_frames("lr", 20);
    px("lr_last_fill", BX + 9, BY + 2, 1, RED);
    px("lr_first_empty", BX + 10, BY + 2, 1, GREY);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
